// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the serial pattern detector controller.
package seq_detect_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // DEF_LEN is clamped to the instance's PAT_W at reset, so 8 means "full width"
    localparam int   DEF_LEN     = 8;
    localparam logic DEF_OVERLAP = 1'b1;
    localparam int   DEF_THRESH  = 0;

    function automatic int clamp_len(input int len, input int max_len);
        int res;
        if (len < 1) begin
            res = 1;
        end else if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Byte stream valid/ready handshake into the detector controller.
interface seq_detect_ctrl_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/seq_detect_ctrl_matcher.sv
// Bit-serial pattern matcher: shift history, fill tracking, masked compare.
module seq_matcher
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = 4,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] hist_r;
    logic [LEN_W-1:0] fill_r;
    logic             match_r;
    logic [PAT_W-1:0] hist_next_s;
    logic [PAT_W-1:0] mask_s;
    logic [LEN_W-1:0] fill_next_s;
    logic [LEN_W-1:0] eff_len_s;
    logic             hit_s;

    // Next history/fill and masked compare against the low L pattern bits
    always_comb begin
        eff_len_s   = LEN_W'(clamp_len(int'(len), PAT_W));
        hist_next_s = {hist_r[PAT_W-2:0], bit_in};
        if (fill_r >= LEN_W'(PAT_W)) begin
            fill_next_s = LEN_W'(PAT_W);
        end else begin
            fill_next_s = fill_r + LEN_W'(1);
        end
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (i < int'(eff_len_s));
        end
        hit_s = (fill_next_s >= eff_len_s) &&
                (((hist_next_s ^ pattern) & mask_s) == {PAT_W{1'b0}});
    end

    // History/fill state and registered match pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            match_r <= 1'b0;
        end else if (clr) begin
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {LEN_W{1'b0}};
            match_r <= 1'b0;
        end else if (bit_vld) begin
            hist_r  <= hist_next_s;
            match_r <= hit_s;
            // Non-overlapping mode must refill a whole pattern before the next hit
            if (hit_s && !overlap) begin
                fill_r <= {LEN_W{1'b0}};
            end else begin
                fill_r <= fill_next_s;
            end
        end else begin
            match_r <= 1'b0;
        end
    end

    assign match = match_r;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-to-bit serializer, configuration registers, match counter and sticky irq
// around the bit-serial pattern matcher.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = 4,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    seq_detect_ctrl_if.slave   strm,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy
);

    state_t           state_r;
    logic [7:0]       byte_r;
    logic [2:0]       bit_idx_r;
    logic             busy_r;
    logic [PAT_W-1:0] pattern_r;
    logic [LEN_W-1:0] len_r;
    logic             overlap_r;
    logic [CNT_W-1:0] thresh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             irq_r;

    logic             ready_s;
    logic             hs_s;
    logic             cfg_acc_s;
    logic             match_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             irq_set_s;

    // Ready is withheld whenever a config write is presented so the two never coincide
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = !cfg_we;
            SHIFT:   ready_s = (bit_idx_r == 3'd0) && !cfg_we;
            default: ready_s = 1'b0;
        endcase
    end

    assign strm.s_ready = ready_s & ~rst;
    assign hs_s         = strm.s_valid & ready_s;
    assign cfg_acc_s    = cfg_we && (state_r == IDLE);

    // Saturating counter next value and threshold-crossing detect
    always_comb begin
        if (match_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        irq_set_s = match_s && (thresh_r != {CNT_W{1'b0}}) &&
                    (cnt_next_s == thresh_r) && (cnt_r != thresh_r);
    end

    // Serializer FSM: one bit per clock, MSB first, back-to-back reload at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            byte_r    <= 8'h00;
            bit_idx_r <= 3'd0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        byte_r    <= strm.s_data;
                        bit_idx_r <= 3'd7;
                        state_r   <= SHIFT;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_idx_r != 3'd0) begin
                        bit_idx_r <= bit_idx_r - 3'd1;
                        busy_r    <= 1'b1;
                    end else if (hs_s) begin
                        byte_r    <= strm.s_data;
                        bit_idx_r <= 3'd7;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Runtime configuration, only writable while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r <= {PAT_W{1'b0}};
            len_r     <= LEN_W'((DEF_LEN > PAT_W) ? PAT_W : DEF_LEN);
            overlap_r <= DEF_OVERLAP;
            thresh_r  <= CNT_W'(DEF_THRESH);
        end else if (cfg_acc_s) begin
            pattern_r <= cfg_pattern;
            len_r     <= cfg_len;
            overlap_r <= cfg_overlap;
            thresh_r  <= cfg_thresh;
        end
    end

    // Match counter and sticky interrupt; a set beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            irq_r <= 1'b0;
        end else if (cfg_acc_s) begin
            cnt_r <= {CNT_W{1'b0}};
            irq_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end
        end
    end

    seq_matcher #(.PAT_W(PAT_W)) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clr     (cfg_acc_s),
        .bit_vld (state_r == SHIFT),
        .bit_in  (byte_r[bit_idx_r]),
        .pattern (pattern_r),
        .len     (len_r),
        .overlap (overlap_r),
        .match   (match_s)
    );

    assign match     = match_s;
    assign match_cnt = cnt_r;
    assign irq       = irq_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed match cycles/counts, a monitor pops on each match pulse.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic [2:0] cfg_len = 3'd4;
    logic       cfg_overlap = 1'b1;
    logic [7:0] cfg_thresh = 8'd0;
    logic       irq_clr = 1'b0;
    logic       match, irq, busy;
    logic [7:0] match_cnt;
    logic       match2, irq2, busy2;
    logic [1:0] match_cnt2;

    seq_detect_ctrl_if bus ();
    seq_detect_ctrl_if bus2 ();

    assign bus2.s_valid = bus.s_valid;
    assign bus2.s_data  = bus.s_data;

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .strm(bus), .match(match), .match_cnt(match_cnt), .irq(irq),
        .irq_clr(irq_clr), .busy(busy)
    );

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh[1:0]),
        .strm(bus2), .match(match2), .match_cnt(match_cnt2), .irq(irq2),
        .irq_clr(irq_clr), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cycles = 0;
    always @(negedge clk) if (busy === 1'b1) busy_cycles <= busy_cycles + 1;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    typedef struct { int cyc; int cnt; } exp_t;
    exp_t q[$];
    exp_t cur;
    logic cnt_pending = 1'b0;
    int   cnt_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every match pulse, checks its cycle and the following count
    always @(negedge clk) begin
        if (cnt_pending) begin
            check("match_cnt_after_match", match_cnt, cnt_exp);
            cnt_pending <= 1'b0;
        end
        if (match === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_match: got match at cycle %0d, expected none", cyc);
            end else begin
                cur = q.pop_front();
                check("match_cycle", cyc, cur.cyc);
                cnt_pending <= 1'b1;
                cnt_exp     <= cur.cnt;
            end
        end
    end

    task automatic exp_match(input int hs, input int k);
        exp_t e;
        exp_cnt++;
        e.cyc = hs + k;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit hold, output int hs);
        int guard = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: got no s_ready in %0d cycles, expected handshake", guard);
            bus.s_valid = 1'b0;
            hs = -1;
        end else begin
            hs = cyc + 1;
            @(posedge clk);
            #1;
            if (!hold) bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || busy === 1'b1 || cnt_pending) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending matches, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [3:0] pat, input logic [2:0] len, input logic ov, input logic [7:0] thr);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_thresh  = thr;
        cfg_we      = 1'b1;
        #1;
        check("s_ready_low_during_cfg_we", bus.s_ready, 1'b0);
        @(negedge clk);
        cfg_we  = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    int hs, h1, h2, h3, b0;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #12;
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_match", match, 1'b0);
        check("rst_match_cnt", match_cnt, 8'd0);
        check("rst_irq", irq, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", bus.s_ready, 1'b1);

        // Partial byte aborted by reset
        cfg_write(4'b1011, 3'd4, 1'b1, 8'd0);
        send_byte(8'hB6, 1'b0, hs);
        wait_cyc(hs + 3);
        check("busy_mid_byte", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_s_ready", bus.s_ready, 1'b0);
        check("midrst_match", match, 1'b0);
        check("midrst_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check("post_midrst_s_ready", bus.s_ready, 1'b1);

        // Default config (pattern 0000, len 4, overlap) applies after reset
        send_byte(8'h0F, 1'b0, hs);
        exp_match(hs, 4);
        drain();
        check("default_cfg_cnt", match_cnt, 8'd1);

        // Overlapping 1011 on 0xB6
        cfg_write(4'b1011, 3'd4, 1'b1, 8'd0);
        send_byte(8'hB6, 1'b0, hs);
        exp_match(hs, 4);
        exp_match(hs, 7);
        drain();
        check("overlap_cnt", match_cnt, 8'd2);
        check("overlap_irq", irq, 1'b0);

        // Non-overlapping
        cfg_write(4'b1011, 3'd4, 1'b0, 8'd0);
        send_byte(8'hB6, 1'b0, hs);
        exp_match(hs, 4);
        drain();
        check("nonoverlap_cnt", match_cnt, 8'd1);

        // Back-to-back bytes with s_valid held
        cfg_write(4'b1011, 3'd4, 1'b1, 8'd0);
        b0 = busy_cycles;
        send_byte(8'hB6, 1'b1, h1);
        exp_match(h1, 4);
        exp_match(h1, 7);
        send_byte(8'hB6, 1'b1, h2);
        exp_match(h2, 4);
        exp_match(h2, 7);
        send_byte(8'hB6, 1'b0, h3);
        exp_match(h3, 4);
        exp_match(h3, 7);
        drain();
        check("b2b_spacing_1", h2 - h1, 8);
        check("b2b_spacing_2", h3 - h2, 8);
        check("b2b_busy_cycles", busy_cycles - b0, 24);
        check("b2b_cnt", match_cnt, 8'd6);

        // Config write during SHIFT is ignored
        cfg_write(4'b1011, 3'd4, 1'b1, 8'd0);
        send_byte(8'hB6, 1'b0, hs);
        exp_match(hs, 4);
        exp_match(hs, 7);
        @(negedge clk);
        @(negedge clk);
        cfg_pattern = 4'b0000;
        cfg_len     = 3'd1;
        cfg_overlap = 1'b0;
        cfg_we      = 1'b1;
        #1;
        check("busy_cfg_s_ready", bus.s_ready, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
        drain();
        check("busy_cfg_cnt", match_cnt, 8'd2);

        // Threshold 3 on a len-1 pattern of 1
        cfg_write(4'b0001, 3'd1, 1'b1, 8'd3);
        send_byte(8'hFF, 1'b0, hs);
        for (int k = 1; k <= 8; k++) exp_match(hs, k);
        wait_cyc(hs + 3);
        check("irq_before_thresh", irq, 1'b0);
        wait_cyc(hs + 4);
        check("irq_at_thresh", irq, 1'b1);
        drain();
        check("thresh_cnt", match_cnt, 8'd8);
        check("sat_cnt_w2", match_cnt2, 2'd3);
        check("irq_cnt_w2", irq2, 1'b1);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", irq, 1'b0);
        check("irq_cleared_w2", irq2, 1'b0);

        // irq_clr coincident with the set edge: set wins
        cfg_write(4'b0001, 3'd1, 1'b1, 8'd3);
        send_byte(8'hFF, 1'b0, hs);
        for (int k = 1; k <= 8; k++) exp_match(hs, k);
        wait_cyc(hs + 3);
        irq_clr = 1'b1;
        wait_cyc(hs + 4);
        irq_clr = 1'b0;
        check("irq_set_beats_clr", irq, 1'b1);
        drain();
        check("irq_sticky_after", irq, 1'b1);

        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
